// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch stage.
// Default widths, reset PC, queue depth and the packed queue-entry width.
package if_prefetch_pkg;

    localparam logic [31:0] IF_PC_RESET   = 32'hbfc0_0000;
    localparam int          IF_Q_DEPTH    = 4;
    localparam int          IF_PC_W       = 32;
    localparam int          IF_INST_W     = 32;
    localparam int          IF_Q_ENTRY_WD = IF_PC_W + IF_INST_W;

    // Occupancy counter width: one extra bit so that "full" is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Bus bundle of the fetch stage: redirect input, instruction SRAM port and
// the valid/ready delivery channel towards ID.
interface if_prefetch_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              br_e;
    logic [PC_W-1:0]   br_addr;

    logic              inst_sram_en;
    logic [3:0]        inst_sram_wen;
    logic [PC_W-1:0]   inst_sram_addr;
    logic [31:0]       inst_sram_wdata;
    logic [INST_W-1:0] inst_sram_rdata;

    logic              id_valid;
    logic              id_ready;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;

    logic [CNT_W-1:0]  q_count;

    modport master (
        input  br_e, br_addr, inst_sram_rdata, id_ready,
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output id_valid, id_pc, id_inst, q_count
    );

    modport slave (
        output br_e, br_addr, inst_sram_rdata, id_ready,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  id_valid, id_pc, id_inst, q_count
    );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous circular FIFO holding packed {pc, inst} entries.
// Pointers carry one wrap bit; flush wins over push, a same-cycle pop is simply absorbed.
module if_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/if_prefetch.sv
// Prefetching fetch stage: issues sequential/redirected SRAM reads, queues the
// returned {pc, inst} pairs and hands them to ID over valid/ready.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int              PC_W     = IF_PC_W,
    parameter int              INST_W   = IF_INST_W,
    parameter int              DEPTH    = IF_Q_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(IF_PC_RESET)
) (
    input  logic          clk,
    input  logic          resetn,
    if_prefetch_if.master bus
);
    localparam int CNT_W   = cnt_width(DEPTH);
    localparam int ENTRY_W = PC_W + INST_W;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return a & ~PC_W'(3);
    endfunction

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    fetch_pc_nxt;
    logic [PC_W-1:0]    req_addr;
    logic               inflight;
    logic               inflight_nxt;
    logic               issue;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     committed;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] head;

    // Credit counts the in-flight slot before any pop, so a push always finds room.
    assign committed = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue     = !bus.br_e && !full && (committed < (CNT_W + 1)'(DEPTH));

    // A response landing in a redirect cycle is dropped by the flush taking priority.
    assign push  = inflight;
    assign pop   = !empty && bus.id_ready;
    assign entry = {req_addr, bus.inst_sram_rdata};

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        inflight_nxt = issue;
        if (bus.br_e) begin
            fetch_pc_nxt = word_align(bus.br_addr);
        end else if (issue) begin
            fetch_pc_nxt = fetch_pc + PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            inflight <= inflight_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) req_addr <= fetch_pc;
    end

    if_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .flush  (bus.br_e),
        .din    (entry),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Gating with resetn keeps the request low the instant reset asserts.
    assign bus.inst_sram_en    = issue && resetn;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = fetch_pc;
    assign bus.inst_sram_wdata = 32'h0;

    assign bus.id_valid = !empty;
    assign bus.id_pc    = head[ENTRY_W-1:INST_W];
    assign bus.id_inst  = head[INST_W-1:0];
    assign bus.q_count  = count;

endmodule
